// File: rtl/shift_add_mult_seq.sv
// Iterative shift-and-add multiplier: one multiplier bit per clock, unsigned or
// two's-complement per operation, full-width product reported with a done pulse.
module shift_add_mult_seq #(
  parameter  int WA = 8,
  parameter  int WB = 8,
  localparam int PW = WA + WB
) (
  input  logic          clk,
  input  logic          clr_n,
  input  logic          start,
  input  logic          signed_mode,
  input  logic [WA-1:0] a,
  input  logic [WB-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product
);

  localparam int CW = (WA > 1) ? $clog2(WA) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]    state_reg;
  logic [WA-1:0] a_reg;
  logic [WB-1:0] b_reg;
  logic          signed_reg;
  logic [PW-1:0] acc_reg;
  logic [PW-1:0] acc_next;
  logic [PW-1:0] product_reg;
  logic          done_reg;
  logic [CW-1:0] cnt_reg;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] addend;
  logic          last_bit;

  // Upper bits of the multiplicand copy its sign bit only in signed mode.
  assign b_ext[WB-1:0] = b_reg;
  generate
    for (genvar gi = WB; gi < PW; gi++) begin : g_b_ext
      assign b_ext[gi] = signed_reg & b_reg[WB-1];
    end
  endgenerate

  assign last_bit = (cnt_reg == CW'(WA - 1));
  assign addend   = b_ext << cnt_reg;

  // The sign bit of a carries weight -2^(WA-1), so its partial product is subtracted.
  always_comb begin
    acc_next = acc_reg;
    if (a_reg[cnt_reg]) begin
      if (signed_reg && last_bit) acc_next = acc_reg - addend;
      else                        acc_next = acc_reg + addend;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_reg   <= S_IDLE;
      a_reg       <= '0;
      b_reg       <= '0;
      signed_reg  <= 1'b0;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      product_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            a_reg      <= a;
            b_reg      <= b;
            signed_reg <= signed_mode;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            state_reg  <= S_RUN;
          end
        end
        default: begin
          acc_reg <= acc_next;
          if (last_bit) begin
            product_reg <= acc_next;
            done_reg    <= 1'b1;
            cnt_reg     <= '0;
            state_reg   <= S_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy    = (state_reg == S_RUN);
  assign done    = done_reg;
  assign product = product_reg;

endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for shift_add_mult_seq: vector table for 8x8 products plus
// hand-written sequences for busy-start, back-to-back, reset abort and a 4x6 instance.
module tb_shift_add_mult_seq;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        start = 1'b0;
  logic        signed_mode = 1'b0;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done;
  logic [15:0] product;

  logic        s_start = 1'b0;
  logic        s_signed = 1'b0;
  logic [3:0]  s_a = '0;
  logic [5:0]  s_b = '0;
  logic        s_busy, s_done;
  logic [9:0]  s_product;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [15:0] last_p = '0;

  always #5 clk = ~clk;

  shift_add_mult_seq #(.WA(8), .WB(8)) u_dut (
    .clk(clk), .clr_n(clr_n), .start(start), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy), .done(done), .product(product)
  );

  shift_add_mult_seq #(.WA(4), .WB(6)) u_dut46 (
    .clk(clk), .clr_n(clr_n), .start(s_start), .signed_mode(s_signed),
    .a(s_a), .b(s_b), .busy(s_busy), .done(s_done), .product(s_product)
  );

  typedef struct {
    logic        sm;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Called just after the accepting edge; follows the 8x8 DUT to its done pulse.
  task automatic wait_done(int exp_cyc, logic [15:0] exp_p, logic [15:0] held, string name);
    int  cyc = 0;
    bit  seen = 0;
    bit  busy_ok = 1;
    bit  held_ok = 1;
    chk({name, "_busy_start"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1;
        cyc = i;
      end else begin
        if (!busy) busy_ok = 0;
        if (product !== held) held_ok = 0;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'(exp_cyc));
    chk({name, "_product"}, 32'(product), 32'(exp_p));
    chk({name, "_busy_end"}, 32'(busy), 32'd0);
    chk({name, "_busy_held"}, 32'(busy_ok), 32'd1);
    chk({name, "_product_held"}, 32'(held_ok), 32'd1);
    $display("op %s: done after %0d cycles product=%h expected=%h", name, cyc, product, exp_p);
  endtask

  // Operand inputs are scrambled after acceptance; they must not matter during RUN.
  task automatic run_op(logic sm, logic [7:0] av, logic [7:0] bv, logic [15:0] exp_p,
                        logic [15:0] held, string name);
    signed_mode = sm; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); signed_mode = 1'($urandom);
    wait_done(8, exp_p, held, name);
  endtask

  task automatic run46(logic sm, logic [3:0] av, logic [5:0] bv, logic [9:0] exp_p, string name);
    int cyc = 0;
    bit seen = 0;
    s_signed = sm; s_a = av; s_b = bv; s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(posedge clk); #1;
      if (s_done) begin
        seen = 1;
        cyc = i;
      end
    end
    chk({name, "_done_seen"}, 32'(seen), 32'd1);
    chk({name, "_latency"}, 32'(cyc), 32'd4);
    chk({name, "_product"}, 32'(s_product), 32'(exp_p));
    $display("op %s: done after %0d cycles product=%h expected=%h", name, cyc, s_product, exp_p);
  endtask

  initial begin
    int done_cnt;
    int done_at;

    vecs[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFE01, "u_ff_ff"};
    vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000, "s_m128_m128"};
    vecs[2] = '{1'b1, 8'hFF, 8'h7F, 16'hFF81, "s_m1_127"};
    vecs[3] = '{1'b1, 8'h03, 8'hFE, 16'hFFFA, "s_3_m2"};
    vecs[4] = '{1'b0, 8'h00, 8'hA5, 16'h0000, "u_zero"};
    vecs[5] = '{1'b0, 8'h01, 8'hA5, 16'h00A5, "u_ident"};
    vecs[6] = '{1'b0, 8'h80, 8'h80, 16'h4000, "u_80_80"};
    vecs[7] = '{1'b1, 8'h7F, 8'h7F, 16'h3F01, "s_127_127"};
    vecs[8] = '{1'b0, 8'hFF, 8'h80, 16'h7F80, "u_ff_80"};

    // Reset values while clr_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    chk("rst46_product", 32'(s_product), 32'd0);
    clr_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sm, vecs[i].a, vecs[i].b, vecs[i].exp, last_p, vecs[i].name);
      last_p = vecs[i].exp;
      @(posedge clk); #1;
      chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
    end

    // Start pulsed while busy must be ignored.
    signed_mode = 1'b0; a = 8'h0C; b = 8'h0A; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    done_cnt = 0;
    done_at = 0;
    for (int i = 1; i <= 18; i++) begin
      if (i == 3) begin start = 1'b1; a = 8'hFF; b = 8'hFF; signed_mode = 1'b1; end
      if (i == 4) start = 1'b0;
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
        chk("ignore_product", 32'(product), 32'h0078);
      end
    end
    chk("ignore_done_count", 32'(done_cnt), 32'd1);
    chk("ignore_done_at", 32'(done_at), 32'd8);
    $display("op ignore_start: done count=%0d at cycle %0d product=%h", done_cnt, done_at, product);
    last_p = 16'h0078;

    // Back-to-back: start raised in the done cycle.
    run_op(1'b0, 8'h0C, 8'h0A, 16'h0078, last_p, "b2b_first");
    chk("b2b_done_now", 32'(done), 32'd1);
    signed_mode = 1'b0; a = 8'h10; b = 8'h10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_done_drop", 32'(done), 32'd0);
    wait_done(8, 16'h0100, 16'h0078, "b2b_second");
    last_p = 16'h0100;
    @(posedge clk); #1;

    // Asynchronous reset in RUN cycle 4.
    signed_mode = 1'b0; a = 8'hFF; b = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    clr_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_product", 32'(product), 32'd0);
    @(posedge clk); #1;
    clr_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    $display("op abort: busy=%0d done=%0d product=%h stray done=%0d", busy, done, product, done_cnt);
    run_op(1'b0, 8'h02, 8'h03, 16'h0006, 16'h0000, "after_abort");
    @(posedge clk); #1;

    // 4x6 instance.
    run46(1'b1, 4'h8, 6'h1F, 10'h308, "p46_signed");
    @(posedge clk); #1;
    run46(1'b0, 4'hF, 6'h3F, 10'h3B1, "p46_unsigned");
    @(posedge clk); #1;
    run46(1'b1, 4'h8, 6'h20, 10'h100, "p46_most_neg");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/shift_add_mult_seq.md
Name: shift_add_mult_seq

Overview:
- Parametrised, iterative shift-and-add multiplier. It is the successor to the fixed 4x4 partial-product blocks in the Abacus datapath.
- Accepts an A x B operand pair on a start strobe and processes one multiplier bit per clock.
- Reports the full-width product with a done pulse.
- Supports unsigned and two's-complement modes, selected per operation.

Parameters:
- WA, 8, width of multiplier operand a (>= 2).
- WB, 8, width of multiplicand operand b (>= 2).
- PW, WA+WB, product width (derived; not to be overridden).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- clr_n  input  1  asynchronous active-low reset.
- start  input  1  request a new multiply; sampled only when idle.
- signed_mode  input  1  1 = both operands two's complement; 0 = unsigned; sampled with start.
- a  input  WA  multiplier operand; sampled with start.
- b  input  WB  multiplicand operand; sampled with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when product is updated.
- product  output  PW  result register; holds last result until the next completion.

Behaviour:
- Reset (clr_n low, asynchronous): state=IDLE, busy=0, done=0, product=0, internal accumulator/counter/operand registers=0.
  - Reset release is synchronous to clk for the first accepted start.
- States: IDLE, RUN.
- IDLE:
  - done is driven low except in the cycle following completion.
  - On a rising edge with start=1: latch a, b and signed_mode; clear accumulator; bit counter=0; busy=1; go to RUN.
- RUN, each rising edge:
  - If a_reg[cnt]=1, add (b_ext << cnt) to the accumulator.
  - b_ext is b_reg zero-extended to PW in unsigned mode and sign-extended to PW in signed mode.
  - Signed mode, cnt = WA-1 (sign bit of a): subtract instead of add.
  - All arithmetic is modulo 2^PW.
  - cnt increments each RUN cycle.
- Completion:
  - On the edge where cnt = WA-1 is processed: product <= final accumulator value, done=1, busy=0, state=IDLE.
- Latency: start sampled at edge k -> product valid and done=1 after edge k+WA; busy high from edge k to edge k+WA.
- Throughput: one result per WA+1 cycles max.
- Back-to-back: start high in the cycle done is high is accepted at the next edge. No bubble beyond the IDLE acceptance cycle.
- start while busy: ignored; operand/mode inputs in RUN are don't-care and must not affect the result.
- done is a single-cycle pulse; it never stays high two consecutive cycles unless two operations complete on consecutive edges (impossible, since WA >= 2).
- product changes only on completion edges or reset; it is stable during RUN.
- Reset mid-operation: operation aborted immediately, outputs to reset values, no done pulse; the next start after release behaves as a fresh operation.
- Results:
  - Unsigned: product = a*b exactly.
  - Signed: product = a*b as PW-bit two's complement, including a = b = most-negative (no overflow, since PW = WA+WB).

Test Plan:
- Unsigned, WA=WB=8: a=0xFF, b=0xFF, start 1 cycle -> busy high 8 cycles; done pulse after edge k+8; product=0xFE01; busy=0 same cycle.
- Signed: a=0x80 (-128), b=0x80 -> product=0x4000. Then a=0xFF (-1), b=0x7F -> product=0xFF81. Then a=0x03, b=0xFE (-2) -> product=0xFFFA.
- Zero and identity, unsigned: a=0x00, b=0xA5 -> product=0x0000. Then a=0x01, b=0xA5 -> 0x00A5. In both, done still pulses after exactly 8 RUN cycles.
- Start while busy: start a=0x0C, b=0x0A, then 3 cycles later pulse start with a=0xFF, b=0xFF -> second start ignored; product=0x0078; exactly one done pulse.
- Back-to-back: start asserted in the done cycle with a=0x10, b=0x10 -> accepted; next done 9 cycles after the previous one; product=0x0100; the previous product held until then.
- Reset mid-op: clr_n low at RUN cycle 4 of a=0xFF, b=0xFF -> busy=0, done=0, product=0 immediately, no done pulse. After release, start a=0x02, b=0x03 -> product=0x0006.
- Parameter sweep: WA=4, WB=6, signed, a=0x8 (-8), b=0x1F (31) -> PW=10, product=0x308 (-248), done after 4 RUN cycles.
